axis_readback_scheduler: RTL

// - Shares the S2MM read-back path of the AXI control wrapper among REQ_COUNT requesters (output managers, debug).
// - Round-robin arbitration; builds the 6-word read-packet header, pulses send_header, waits for read_done, acks requester.
// - Sits between requesters and the wrapper's header_word_0..5 / send_header / read_done ports.

---
 rtl/axis_readback_scheduler_pkg.sv | 35 +++
 rtl/axis_readback_scheduler_rr_arbiter.sv | 35 +++
 rtl/axis_readback_scheduler.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/axis_readback_scheduler_pkg.sv
// rtl/axis_readback_scheduler_pkg.sv - shared state encodings, header defaults and header field layout
package axis_readback_scheduler_pkg;

    // Scheduler FSM states
    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_HDR       = 2'd1,
        ST_WAIT_DONE = 2'd2,
        ST_ACK       = 2'd3
    } rb_state_t;

    // Header defaults
    localparam logic [15:0] DEFAULT_MAGIC      = 16'hA5A5;
    localparam logic [7:0]  DEFAULT_INSTR_READ = 8'h02;

    // Header word positions
    localparam int HDR_WORDS      = 6;
    localparam int HDR_MAGIC      = 0;
    localparam int HDR_INSTR      = 1;
    localparam int HDR_BRAM       = 2;
    localparam int HDR_ADDR_START = 3;
    localparam int HDR_ADDR_COUNT = 4;
    localparam int HDR_SEQ        = 5;

    // Word 1: instruction in the upper byte, requester id in the low bits
    function automatic logic [15:0] hdr_instr_word(input logic [7:0] instr, input logic [2:0] id);
        return {instr, 5'b0, id};
    endfunction

    // Word 2: BRAM start/end packed in the low six bits
    function automatic logic [15:0] hdr_bram_word(input logic [2:0] bram_start, input logic [2:0] bram_end);
        return {10'b0, bram_start, bram_end};
    endfunction

endpackage

// File: rtl/axis_readback_scheduler_rr_arbiter.sv
// rtl/axis_readback_scheduler_rr_arbiter.sv - combinational round-robin pick starting at the pointer
module axis_readback_scheduler_rr_arbiter #(
    parameter int REQ_COUNT = 4
) (
    input  logic [REQ_COUNT-1:0] req,
    input  logic [2:0]           pointer,
    output logic [REQ_COUNT-1:0] winner,
    output logic [2:0]           winner_id,
    output logic                 valid
);

    localparam int IDX_W = (REQ_COUNT > 1) ? $clog2(REQ_COUNT) : 1;

    logic [IDX_W-1:0] lane_ix;
    int               lane;

    // Scan from the pointer upward with wrap; the first asserted request wins
    always_comb begin
        winner    = '0;
        winner_id = '0;
        valid     = 1'b0;
        lane      = 0;
        lane_ix   = '0;
        for (int i = 0; i < REQ_COUNT; i++) begin
            lane    = (int'(pointer) + i) % REQ_COUNT;
            lane_ix = IDX_W'(lane);
            if (!valid && req[lane_ix]) begin
                valid           = 1'b1;
                winner[lane_ix] = 1'b1;
                winner_id       = 3'(lane);
            end
        end
    end

endmodule

// File: rtl/axis_readback_scheduler.sv
// rtl/axis_readback_scheduler.sv - round-robin owner of the read-back header path; optional watchdog under READBACK_TIMEOUT_EN
module axis_readback_scheduler
    import axis_readback_scheduler_pkg::*;
#(
    parameter int          REQ_COUNT      = 4,
    parameter logic [15:0] MAGIC          = DEFAULT_MAGIC,
    parameter logic [7:0]  INSTR_READ     = DEFAULT_INSTR_READ,
    parameter int          TIMEOUT_CYCLES = 65535
) (
    input  logic                    aclk,
    input  logic                    areset,
    input  logic [REQ_COUNT-1:0]    req,
    input  logic [3*REQ_COUNT-1:0]  req_bram_start_flat,
    input  logic [3*REQ_COUNT-1:0]  req_bram_end_flat,
    input  logic [16*REQ_COUNT-1:0] req_addr_start_flat,
    input  logic [16*REQ_COUNT-1:0] req_addr_count_flat,
    output logic [REQ_COUNT-1:0]    grant,
    output logic [REQ_COUNT-1:0]    done,
    output logic [15:0]             header_word_0,
    output logic [15:0]             header_word_1,
    output logic [15:0]             header_word_2,
    output logic [15:0]             header_word_3,
    output logic [15:0]             header_word_4,
    output logic [15:0]             header_word_5,
    output logic                    send_header,
    input  logic                    read_done,
    output logic                    busy,
    output logic [15:0]             seq_num,
    output logic                    error_timeout
);

    rb_state_t              state_q;
    rb_state_t              state_d;
    logic [2:0]             ptr_q;
    logic [2:0]             owner_q;
    logic [REQ_COUNT-1:0]   grant_q;
    logic [15:0]            hdr_q [HDR_WORDS];
    logic [15:0]            seq_q;

    logic [REQ_COUNT-1:0]   arb_winner;
    logic [2:0]             arb_id;
    logic                   arb_valid;

    logic [2:0]             sel_bram_start;
    logic [2:0]             sel_bram_end;
    logic [15:0]            sel_addr_start;
    logic [15:0]            sel_addr_count;
    logic                   take;
    logic                   wd_expire;

    axis_readback_scheduler_rr_arbiter #(
        .REQ_COUNT (REQ_COUNT)
    ) u_arb (
        .req       (req),
        .pointer   (ptr_q),
        .winner    (arb_winner),
        .winner_id (arb_id),
        .valid     (arb_valid)
    );

    // One-hot AND-OR mux: only the winning lane's parameters reach the header
    always_comb begin
        sel_bram_start = '0;
        sel_bram_end   = '0;
        sel_addr_start = '0;
        sel_addr_count = '0;
        for (int i = 0; i < REQ_COUNT; i++) begin
            if (arb_winner[i]) begin
                sel_bram_start = sel_bram_start | req_bram_start_flat[i*3 +: 3];
                sel_bram_end   = sel_bram_end   | req_bram_end_flat[i*3 +: 3];
                sel_addr_start = sel_addr_start | req_addr_start_flat[i*16 +: 16];
                sel_addr_count = sel_addr_count | req_addr_count_flat[i*16 +: 16];
            end
        end
    end

    assign take = (state_q == ST_IDLE) && arb_valid;

`ifdef READBACK_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [WD_W-1:0] wd_q;
    logic            err_q;

    assign wd_expire = (state_q == ST_WAIT_DONE) && !read_done &&
                       (wd_q == WD_W'(TIMEOUT_CYCLES - 1));

    // Watchdog counts WAIT_DONE cycles from zero; the error flag is sticky
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            wd_q  <= '0;
            err_q <= 1'b0;
        end else begin
            if (state_q == ST_HDR) begin
                wd_q <= '0;
            end else if (state_q == ST_WAIT_DONE) begin
                wd_q <= wd_q + 1'b1;
            end
            if (wd_expire) begin
                err_q <= 1'b1;
            end
        end
    end

    assign error_timeout = err_q;
`else
    assign wd_expire     = 1'b0;
    assign error_timeout = 1'b0;
`endif

    // FSM state register
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and decoded outputs; read_done only matters while waiting
    always_comb begin
        state_d     = state_q;
        send_header = 1'b0;
        done        = '0;
        busy        = (state_q != ST_IDLE);
        case (state_q)
            ST_IDLE: begin
                if (arb_valid) begin
                    state_d = (sel_addr_count == 16'd0) ? ST_ACK : ST_HDR;
                end
            end
            ST_HDR: begin
                send_header = 1'b1;
                state_d     = ST_WAIT_DONE;
            end
            ST_WAIT_DONE: begin
                if (read_done || wd_expire) begin
                    state_d = ST_ACK;
                end
            end
            ST_ACK: begin
                done    = grant_q;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Grant, header capture on arbitration; pointer advance and sequence count on ack
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            grant_q <= '0;
            owner_q <= '0;
            ptr_q   <= '0;
            seq_q   <= '0;
            for (int i = 0; i < HDR_WORDS; i++) begin
                hdr_q[i] <= '0;
            end
        end else if (take) begin
            grant_q                 <= arb_winner;
            owner_q                 <= arb_id;
            hdr_q[HDR_MAGIC]        <= MAGIC;
            hdr_q[HDR_INSTR]        <= hdr_instr_word(INSTR_READ, arb_id);
            hdr_q[HDR_BRAM]         <= hdr_bram_word(sel_bram_start, sel_bram_end);
            hdr_q[HDR_ADDR_START]   <= sel_addr_start;
            hdr_q[HDR_ADDR_COUNT]   <= sel_addr_count;
            hdr_q[HDR_SEQ]          <= seq_q;
        end else if (state_q == ST_ACK) begin
            grant_q <= '0;
            ptr_q   <= (owner_q == 3'(REQ_COUNT - 1)) ? 3'd0 : owner_q + 3'd1;
            seq_q   <= seq_q + 16'd1;
        end
    end

    assign grant         = grant_q;
    assign seq_num       = seq_q;
    assign header_word_0 = hdr_q[HDR_MAGIC];
    assign header_word_1 = hdr_q[HDR_INSTR];
    assign header_word_2 = hdr_q[HDR_BRAM];
    assign header_word_3 = hdr_q[HDR_ADDR_START];
    assign header_word_4 = hdr_q[HDR_ADDR_COUNT];
    assign header_word_5 = hdr_q[HDR_SEQ];

endmodule
